// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads a 16-word program ROM at PC, resolves
// unconditional jumps locally, and presents one registered instruction
// to the decoder through a valid/ready handshake.
// Execute-stage redirects flush the slot and reload PC.
module fetch_unit #(
    parameter logic [3:0] OPC_JMP = 4'b1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_inst,
    output logic [15:0] inst_out,
    output logic [3:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [3:0]  redirect_addr,
    output logic [7:0]  fetch_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_pc;
    logic [15:0] r_inst;
    logic [3:0]  r_inst_pc;
    logic        r_valid;
    logic [7:0]  r_count;

    logic        w_slot_free;
    logic        w_handshake;
    logic        w_fetch;
    logic        w_is_jmp;

    // Output slot can take a new word when empty or being drained this cycle.
    assign w_slot_free = !r_valid || inst_ready;
    assign w_handshake = r_valid && inst_ready;
    assign w_is_jmp    = (rom_inst[15:12] == OPC_JMP);

    // The IDLE->RUN edge already fetches, so the first word comes from the
    // same edge that sees run=1; fetching therefore only depends on run.
    assign w_fetch = run && w_slot_free && !redirect;

    assign rom_addr    = r_pc;
    assign inst_out    = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_valid  = r_valid;
    assign fetch_count = r_count;

    // Run/idle control: leave RUN only once the pending word has drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (run) r_state <= S_RUN;
                S_RUN:   if (!run && !r_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // PC and instruction slot; redirect beats fetch, which beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= 4'd0;
            r_inst    <= 16'h0000;
            r_inst_pc <= 4'd0;
            r_valid   <= 1'b0;
        end else if (redirect) begin
            r_valid <= 1'b0;
            r_pc    <= redirect_addr;
        end else if (w_fetch) begin
            if (w_is_jmp) begin
                // Jump is consumed here: bubble the slot and retarget PC.
                r_valid <= 1'b0;
                r_pc    <= rom_inst[3:0];
            end else begin
                r_inst    <= rom_inst;
                r_inst_pc <= r_pc;
                r_valid   <= 1'b1;
                r_pc      <= r_pc + 4'd1;
            end
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    // Delivered-instruction counter, saturating at 255; counts accepts on
    // redirect cycles too since the word left before the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (w_handshake && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential flow with jump bubble, stall,
// redirect, async reset, PC wrap, run=0 drain and counter saturation.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [3:0]  rom_addr;
    logic [15:0] rom_inst;
    logic [15:0] inst_out;
    logic [3:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [3:0]  redirect_addr;
    logic [7:0]  fetch_count;

    logic [15:0] rom [16];

    int n_vec;
    int n_err;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_count   (fetch_count)
    );

    // Combinational program ROM.
    assign rom_inst = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the whole output set; inst_out/inst_pc only when a word is expected.
    task automatic chk_st(input string tag, input logic v, input logic [3:0] pc,
                          input logic [15:0] ins, input logic [3:0] addr, input logic [7:0] cnt);
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"},   {28'd0, inst_pc},  {28'd0, pc});
            chk({tag, ".inst"}, {16'd0, inst_out}, {16'd0, ins});
        end
        chk({tag, ".addr"},  {28'd0, rom_addr},    {28'd0, addr});
        chk({tag, ".count"}, {24'd0, fetch_count}, {24'd0, cnt});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, ".pc"},    {28'd0, inst_pc},    32'd0);
        chk({tag, ".inst"},  {16'd0, inst_out},   32'd0);
        chk({tag, ".addr"},  {28'd0, rom_addr},   32'd0);
        chk({tag, ".count"}, {24'd0, fetch_count}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1E09; rom[1] = 16'hFE00; rom[2] = 16'h100A; rom[3] = 16'hF000;
        rom[4] = 16'hE1C0; rom[5] = 16'hF000; rom[6] = 16'h8000;
        rst = 1'b1; run = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_addr = 4'd0;

        // Reset state.
        #12;
        chk_zero("reset");

        // Sequential flow with a jump at address 6 back to 0.
        rst = 1'b0; run = 1'b1; inst_ready = 1'b1;
        step(); chk_st("seq0", 1'b1, 4'd0, 16'h1E09, 4'd1, 8'd0);
        step(); chk_st("seq1", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd1);
        step(); chk_st("seq2", 1'b1, 4'd2, 16'h100A, 4'd3, 8'd2);
        step(); chk_st("seq3", 1'b1, 4'd3, 16'hF000, 4'd4, 8'd3);
        step(); chk_st("seq4", 1'b1, 4'd4, 16'hE1C0, 4'd5, 8'd4);
        step(); chk_st("seq5", 1'b1, 4'd5, 16'hF000, 4'd6, 8'd5);
        step(); chk_st("jmp_bubble", 1'b0, 4'd0, 16'h0000, 4'd0, 8'd6);
        step(); chk_st("seq0b", 1'b1, 4'd0, 16'h1E09, 4'd1, 8'd6);
        step(); chk_st("seq1b", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd7);

        // Decoder stall for three cycles holds everything.
        inst_ready = 1'b0;
        step(); chk_st("stall1", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd7);
        step(); chk_st("stall2", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd7);
        step(); chk_st("stall3", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd7);
        inst_ready = 1'b1;
        step(); chk_st("resume", 1'b1, 4'd2, 16'h100A, 4'd3, 8'd8);

        // Redirect while stalled: flush, then refetch from 4.
        inst_ready = 1'b0; redirect = 1'b1; redirect_addr = 4'd4;
        step(); chk_st("redir", 1'b0, 4'd0, 16'h0000, 4'd4, 8'd8);
        redirect = 1'b0; inst_ready = 1'b1;
        step(); chk_st("redir_tgt", 1'b1, 4'd4, 16'hE1C0, 4'd5, 8'd8);
        step(); chk_st("redir_next", 1'b1, 4'd5, 16'hF000, 4'd6, 8'd9);

        // Asynchronous reset mid-stream, released between edges.
        #2 rst = 1'b1;
        #1 chk_zero("arst_now");
        step(); chk_zero("arst_held");
        #2 rst = 1'b0;
        step(); chk_st("restart0", 1'b1, 4'd0, 16'h1E09, 4'd1, 8'd0);
        step(); chk_st("restart1", 1'b1, 4'd1, 16'hFE00, 4'd2, 8'd1);

        // PC wrap with a nop-filled ROM; redirect also counts the accepted word.
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[15] = 16'h7777;
        redirect = 1'b1; redirect_addr = 4'd14;
        step(); chk_st("redir_hs", 1'b0, 4'd0, 16'h0000, 4'd14, 8'd2);
        redirect = 1'b0;
        step(); chk_st("wrap14", 1'b1, 4'd14, 16'h0000, 4'd15, 8'd2);
        step(); chk_st("wrap15", 1'b1, 4'd15, 16'h7777, 4'd0, 8'd3);
        step(); chk_st("wrap0", 1'b1, 4'd0, 16'h0000, 4'd1, 8'd4);
        step(); chk_st("wrap1", 1'b1, 4'd1, 16'h0000, 4'd2, 8'd5);

        // run=0: pending word held until accepted, then slot empties, no fetch.
        run = 1'b0; inst_ready = 1'b0;
        step(); chk_st("halt_hold", 1'b1, 4'd1, 16'h0000, 4'd2, 8'd5);
        inst_ready = 1'b1;
        step(); chk_st("halt_drain", 1'b0, 4'd0, 16'h0000, 4'd2, 8'd6);
        step(); chk_st("halt_idle", 1'b0, 4'd0, 16'h0000, 4'd2, 8'd6);

        // Counter saturation.
        rst = 1'b1;
        #1 rst = 1'b0;
        run = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 255; k++) step();
        chk("cnt254", {24'd0, fetch_count}, 32'd254);
        step();
        chk("cnt255", {24'd0, fetch_count}, 32'd255);
        for (int k = 0; k < 50; k++) step();
        chk("cnt_sat", {24'd0, fetch_count}, 32'd255);
        chk("sat_valid", {31'd0, inst_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter OPC_JMP, default 4'b1000, opcode resolved locally as unconditional jump.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  fetch enable; 0 = no new fetches.
REQ-005 SHALL have port rom_addr  output  4  address to program ROM, equal to PC register.
REQ-006 SHALL have port rom_inst  input  16  instruction returned combinationally by ROM for rom_addr.
REQ-007 SHALL have port inst_out  output  16  registered instruction presented to decoder.
REQ-008 SHALL have port inst_pc  output  4  address the inst_out word was fetched from.
REQ-009 SHALL have port inst_valid  output  1  inst_out/inst_pc hold a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  decoder accepts inst_out this cycle.
REQ-011 SHALL have port redirect  input  1  execute-stage branch taken; flush and refetch.
REQ-012 SHALL have port redirect_addr  input  4  target for redirect.
REQ-013 SHALL have port fetch_count  output  8  count of instructions delivered (handshakes), saturating.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE->RUN when run=1; RUN->IDLE when run=0 and inst_valid=0.
REQ-015 SHALL define slot-free = (inst_valid=0) or (inst_valid=1 and inst_ready=1).
REQ-016 SHALL, in RUN with run=1, slot-free and redirect=0, fetch: opcode = rom_inst[15:12].
REQ-017 SHALL, on fetch with opcode != OPC_JMP, load inst_out<=rom_inst, inst_pc<=PC, inst_valid<=1, PC<=PC+1.
REQ-018 SHALL, on fetch with opcode == OPC_JMP, not forward the word, set PC<=rom_inst[3:0], and set inst_valid<=0 (one-cycle bubble).
REQ-019 SHALL wrap PC+1 modulo 16 (15 -> 0); no flag, no stall.
REQ-020 SHALL, when slot not free (valid and not ready), hold inst_out, inst_pc, inst_valid and PC unchanged.
REQ-021 SHALL, when run=0, perform no fetch; a pending valid word stays presented until accepted, then inst_valid<=0.
REQ-022 SHALL give redirect priority over every other event: inst_valid<=0, PC<=redirect_addr, no fetch that cycle, regardless of inst_ready or opcode.
REQ-023 SHALL count a handshake on redirect cycles if inst_valid=1 and inst_ready=1 (word accepted before flush).
REQ-024 SHALL increment fetch_count on every inst_valid=1 and inst_ready=1 cycle, saturating at 255.
REQ-025 SHALL give fetch latency of one cycle: word at PC appears on inst_out the cycle after fetch.
REQ-026 SHALL sustain one delivered instruction per cycle with inst_ready held 1 and no jumps.
REQ-027 SHALL drive rom_addr = PC combinationally from the register at all times.
REQ-028 SHALL forward opcode 0000 (nop) and all other opcodes unchanged.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-stall or mid-redirect, immediately set state=IDLE, PC=0, rom_addr=0, inst_out=16'h0000, inst_pc=0, inst_valid=0, fetch_count=0.
REQ-030 SHALL perform first fetch from address 0 on the first rising edge with rst=0 and run=1.

Verification
REQ-031 SHALL verify ROM {0:1E09, 1:FE00, 2:100A, 3:F000, 4:E1C0, 5:F000, 6:8000}, run=1, ready=1 -> inst_pc sequence 0,1,2,3,4,5, one bubble, then 0,1,... again; 8000 never on inst_out.
REQ-032 SHALL verify inst_ready=0 for 3 cycles with inst_out=FE00 valid -> inst_out, inst_pc=1, rom_addr=2 held; fetch_count unchanged; resumes next cycle after ready=1.
REQ-033 SHALL verify redirect=1, redirect_addr=4 while inst_valid=1, ready=0 -> next cycle inst_valid=0, rom_addr=4; following cycle inst_out=E1C0, inst_pc=4.
REQ-034 SHALL verify ROM filled with 0000 except 15 -> inst_pc runs 14, 15, 0 with no bubble at wrap.
REQ-035 SHALL verify rst asserted mid-stream for one cycle, deasserted asynchronously -> all outputs 0 immediately; fetch restarts at address 0.
REQ-036 SHALL verify 300 handshakes -> fetch_count = 255 and stays 255.
